// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR period monitor.
// Constants are built in MaxCntW bits so that 2^64 does not overflow.
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    RUN,
    DONE
  } mon_state_t;

  // Widest supported count: N up to 64 needs N+1 = 65 bits.
  localparam int unsigned MaxCntW = 65;

  function automatic logic [MaxCntW-1:0] step_limit(input int unsigned n);
    return MaxCntW'(1) << n;
  endfunction

  function automatic logic [MaxCntW-1:0] max_period(input int unsigned n);
    return step_limit(n) - MaxCntW'(1);
  endfunction

endpackage

// File: rtl/period_counter.sv
// Step counter for the period monitor: synchronous clear/enable, async reset.
// Exposes the incremented value and a flag when it reaches the step limit.
module period_counter
  import lfsr_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = N + 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_next_o,
  output logic             terminal_o
);

  localparam logic [CNT_W-1:0] StepLimit = CNT_W'(step_limit(N));

  logic [CNT_W-1:0] count_d, count_q;

  always_comb begin
    count_next_o = count_q + CNT_W'(1);
    terminal_o   = (count_next_o == StepLimit);
    count_d      = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_next_o;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lfsr_period_monitor.sv
// Measures the period of an upstream LFSR: captures the first state after start,
// counts valid steps until it recurs, and flags maximal length, lock-up and timeout.
module lfsr_period_monitor
  import lfsr_pkg::*;
#(
  parameter int unsigned N     = 64,
  parameter int unsigned CNT_W = N + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N-1:0]     state_in,
  input  logic             state_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] period,
  output logic             maximal,
  output logic             lockup,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MaxPeriod = CNT_W'(max_period(N));

  mon_state_t       state_d, state_q;
  logic [N-1:0]     ref_d, ref_q;
  logic [CNT_W-1:0] period_d, period_q;
  logic             maximal_d, maximal_q;
  logic             lockup_d, lockup_q;
  logic             timeout_d, timeout_q;
  logic             cnt_clr, cnt_en;
  logic [CNT_W-1:0] count_next;
  logic             terminal;

  period_counter #(
    .N    (N),
    .CNT_W(CNT_W)
  ) u_period_counter (
    .clk_i       (clk),
    .reset_i     (reset),
    .clr_i       (cnt_clr),
    .en_i        (cnt_en),
    .count_next_o(count_next),
    .terminal_o  (terminal)
  );

  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    period_d  = period_q;
    maximal_d = maximal_q;
    lockup_d  = lockup_q;
    timeout_d = timeout_q;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CAPTURE;
          period_d  = '0;
          maximal_d = 1'b0;
          lockup_d  = 1'b0;
          timeout_d = 1'b0;
        end
      end
      CAPTURE: begin
        if (state_valid) begin
          ref_d   = state_in;
          cnt_clr = 1'b1;
          if (state_in == '0) begin
            lockup_d = 1'b1;
            period_d = '0;
            state_d  = DONE;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // Recurrence wins over zero, which wins over the step limit.
        if (state_valid) begin
          if (state_in == ref_q) begin
            period_d  = count_next;
            maximal_d = (count_next == MaxPeriod);
            state_d   = DONE;
          end else if (state_in == '0) begin
            lockup_d = 1'b1;
            period_d = '0;
            state_d  = DONE;
          end else if (terminal) begin
            timeout_d = 1'b1;
            period_d  = '0;
            state_d   = DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ref_q     <= '0;
      period_q  <= '0;
      maximal_q <= 1'b0;
      lockup_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      period_q  <= period_d;
      maximal_q <= maximal_d;
      lockup_q  <= lockup_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy    = (state_q == CAPTURE) || (state_q == RUN);
  assign done    = (state_q == DONE);
  assign period  = period_q;
  assign maximal = maximal_q;
  assign lockup  = lockup_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Scoreboard bench for lfsr_period_monitor at N=4: stimulus pushes expected
// results, a negedge monitor pops and compares on every done pulse.
module tb_lfsr_period_monitor;

  localparam int unsigned N     = 4;
  localparam int unsigned CNT_W = N + 1;

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic             maximal;
    logic             lockup;
    logic             timeout;
  } exp_t;

  logic             clk;
  logic             reset;
  logic             start;
  logic [N-1:0]     state_in;
  logic             state_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] period;
  logic             maximal;
  logic             lockup;
  logic             timeout;

  exp_t sb_q[$];
  int   n_total;
  int   n_pass;
  int   cyc;
  logic busy_lost;

  // x^4+x^3+1 maximal sequence from 4'h1, hand-derived.
  logic [N-1:0] max_seq[15] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                                4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8};
  logic [N-1:0] rho_seq[17] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h4, 4'h5, 4'h6,
                                4'h4, 4'h5, 4'h6, 4'h4, 4'h5, 4'h6, 4'h4, 4'h5};
  logic [N-1:0] five_seq[6] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h1};

  lfsr_period_monitor #(
    .N    (N),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .state_in   (state_in),
    .state_valid(state_valid),
    .busy       (busy),
    .done       (done),
    .period     (period),
    .maximal    (maximal),
    .lockup     (lockup),
    .timeout    (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("period", 32'(period), 32'(e.period));
        check("maximal", 32'(maximal), 32'(e.maximal));
        check("lockup", 32'(lockup), 32'(e.lockup));
        check("timeout", 32'(timeout), 32'(e.timeout));
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cyc++;
  endtask

  task automatic feed(input logic [N-1:0] v, input int gap);
    if (busy !== 1'b1) busy_lost = 1'b1;
    state_in    = v;
    state_valid = 1'b1;
    @(posedge clk);
    #1;
    state_valid = 1'b0;
    cyc++;
    repeat (gap) begin
      if (busy !== 1'b1) busy_lost = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_max(input int gap);
    for (int i = 0; i < 16; i++) begin
      feed(max_seq[i % 15], (i == 15) ? 0 : gap);
    end
  endtask

  task automatic wait_done(input int bound);
    int k;
    k = 0;
    while (k < bound) begin
      @(negedge clk);
      if (done === 1'b1) break;
      k++;
    end
    check("done_seen", 32'(k < bound), 32'd1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    n_total     = 0;
    n_pass      = 0;
    cyc         = 0;
    busy_lost   = 1'b0;
    reset       = 1'b1;
    start       = 1'b0;
    state_in    = '0;
    state_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    check("rst_flags", {29'd0, maximal, lockup, timeout}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Maximal sequence, valid every cycle.
    sb_q.push_back('{period: 5'd15, maximal: 1'b1, lockup: 1'b0, timeout: 1'b0});
    pulse_start();
    run_max(0);
    wait_done(5);
    check("busy_held_dense", 32'(busy_lost), 32'd0);

    // Same sequence, valid every third cycle.
    sb_q.push_back('{period: 5'd15, maximal: 1'b1, lockup: 1'b0, timeout: 1'b0});
    busy_lost = 1'b0;
    cyc = 0;
    pulse_start();
    run_max(2);
    wait_done(5);
    check("sparse_latency_ge46", 32'(cyc >= 46), 32'd1);
    check("busy_held_sparse", 32'(busy_lost), 32'd0);

    // Valid samples in IDLE are ignored and results hold.
    state_in    = 4'h0;
    state_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    state_valid = 1'b0;
    check("idle_hold_period", 32'(period), 32'd15);
    check("idle_busy", 32'(busy), 32'd0);

    // All-zero first sample.
    sb_q.push_back('{period: 5'd0, maximal: 1'b0, lockup: 1'b1, timeout: 1'b0});
    pulse_start();
    feed(4'h0, 0);
    wait_done(3);

    // Short repeating pattern.
    sb_q.push_back('{period: 5'd5, maximal: 1'b0, lockup: 1'b0, timeout: 1'b0});
    pulse_start();
    for (int i = 0; i < 6; i++) feed(five_seq[i], 0);
    wait_done(3);

    // Rho pattern never returns to the captured state.
    sb_q.push_back('{period: 5'd0, maximal: 1'b0, lockup: 1'b0, timeout: 1'b1});
    pulse_start();
    for (int i = 0; i < 17; i++) feed(rho_seq[i], 0);
    wait_done(3);
    check("timeout_held", 32'(timeout), 32'd1);

    sb_q.push_back('{period: 5'd15, maximal: 1'b1, lockup: 1'b0, timeout: 1'b0});
    pulse_start();
    check("timeout_cleared_on_start", 32'(timeout), 32'd0);
    run_max(0);
    wait_done(3);

    // Reset in RUN at count=7: no done, everything zero.
    pulse_start();
    for (int i = 0; i < 8; i++) feed(max_seq[i], 0);
    #2;
    reset = 1'b1;
    #1;
    check("midrun_rst_busy", 32'(busy), 32'd0);
    check("midrun_rst_done", 32'(done), 32'd0);
    check("midrun_rst_results", {26'd0, period, maximal, lockup, timeout}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Recovery run with a stray start while busy.
    sb_q.push_back('{period: 5'd15, maximal: 1'b1, lockup: 1'b0, timeout: 1'b0});
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      start = (i == 5);
      feed(max_seq[i % 15], 0);
    end
    start = 1'b0;
    wait_done(3);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    check("final_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
